// File: rtl/res_pkg.sv
// Shared definitions for the binary-to-BCD result converter: FSM states and sizing constants.
package res_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam int unsigned NSHIFT = 9;
    localparam int unsigned NDIG   = 3;
    localparam int unsigned MAG_W  = 9;
    localparam int unsigned SCR_W  = NDIG * 4;
    localparam int unsigned CNT_W  = 4;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before it is shifted.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/res_bcd_conv.sv
// Converts an adder/subtractor result (S, Cout, Sel) into sign plus three BCD digits
// using a 9-cycle sequential double-dabble.
module res_bcd_conv (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] S,
    input  logic       Cout,
    input  logic       Sel,
    output logic       busy,
    output logic       done,
    output logic       neg,
    output logic [3:0] bcd2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0
);

    import res_pkg::*;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [MAG_W-1:0]       mag_q;
    logic [SCR_W-1:0]       scr_q;
    logic                   sign_q;

    logic                   cap_neg;
    logic [MAG_W-1:0]       cap_mag;
    logic [SCR_W-1:0]       scr_adj;
    logic [SCR_W+MAG_W-1:0] shifted;

    // Subtract without carry-out means the result went negative; undo the two's complement.
    always_comb begin
        cap_neg = Sel & ~Cout;
        cap_mag = {Cout, S};
        if (Sel) begin
            cap_mag = Cout ? {1'b0, S} : ({1'b0, ~S} + 9'd1);
        end
    end

    for (genvar i = 0; i < NDIG; i++) begin : g_digit
        bcd_add3 u_add3 (
            .din  (scr_q[4*i +: 4]),
            .dout (scr_adj[4*i +: 4])
        );
    end

    assign shifted = {scr_adj, mag_q} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mag_q   <= '0;
            scr_q   <= '0;
            sign_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            neg     <= 1'b0;
            bcd2    <= '0;
            bcd1    <= '0;
            bcd0    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_q <= SHIFT;
                        busy    <= 1'b1;
                        sign_q  <= cap_neg;
                        mag_q   <= cap_mag;
                        scr_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    scr_q <= shifted[SCR_W+MAG_W-1 -: SCR_W];
                    mag_q <= shifted[MAG_W-1:0];
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Last shift lands directly in the output registers.
                    if (cnt_q == CNT_W'(NSHIFT - 1)) begin
                        state_q <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        neg     <= sign_q;
                        bcd2    <= shifted[SCR_W+MAG_W-1 -: 4];
                        bcd1    <= shifted[SCR_W+MAG_W-5 -: 4];
                        bcd0    <= shifted[SCR_W+MAG_W-9 -: 4];
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_res_bcd_conv.sv
// Self-checking bench for res_bcd_conv: directed cases, reset abort, and a full A/B sum sweep.
module tb_res_bcd_conv;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] S;
    logic       Cout;
    logic       Sel;
    logic       busy;
    logic       done;
    logic       neg;
    logic [3:0] bcd2;
    logic [3:0] bcd1;
    logic [3:0] bcd0;

    int         n_vec = 0;
    int         n_err = 0;
    logic       prev_neg;
    logic [11:0] prev_dig;

    res_bcd_conv u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .S     (S),
        .Cout  (Cout),
        .Sel   (Sel),
        .busy  (busy),
        .done  (done),
        .neg   (neg),
        .bcd2  (bcd2),
        .bcd1  (bcd1),
        .bcd0  (bcd0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Adder/subtractor front end as seen by the converter.
    function automatic void sum_model(input int a, input int b, input logic sel,
                                      output logic cout, output logic [7:0] s);
        int t;
        t = sel ? (a + (255 - b) + 1) : (a + b);
        cout = t[8];
        s    = t[7:0];
    endfunction

    function automatic logic [11:0] dec_digits(input int v);
        int m;
        m = (v < 0) ? -v : v;
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic randomize_inputs();
        S     = 8'($urandom);
        Cout  = 1'($urandom);
        Sel   = 1'($urandom);
        start = 1'($urandom);
    endtask

    task automatic convert(input logic sel, input logic cout, input logic [7:0] s,
                           input logic exp_neg, input logic [11:0] exp_dig);
        int lat;
        int nbusy;
        @(negedge clk);
        Sel = sel; Cout = cout; S = s; start = 1'b1;
        @(negedge clk);
        lat   = 1;
        nbusy = 0;
        while (!done && lat < 16) begin
            if (busy) nbusy++;
            check("hold", {19'd0, neg, bcd2, bcd1, bcd0}, {19'd0, prev_neg, prev_dig});
            randomize_inputs();
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("latency", lat, 10);
        check("busy_cycles", nbusy, 9);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("neg", {31'd0, neg}, {31'd0, exp_neg});
        check("digits", {20'd0, bcd2, bcd1, bcd0}, {20'd0, exp_dig});
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
        prev_neg = exp_neg;
        prev_dig = exp_dig;
    endtask

    task automatic do_pair(input int a, input int b, input logic sel);
        logic       c;
        logic [7:0] s;
        int         v;
        sum_model(a, b, sel, c, s);
        v = sel ? a - b : a + b;
        convert(sel, c, s, v < 0, dec_digits(v));
    endtask

    logic       seen [1024];
    int         ref_val [1024];
    int         idx_q [$];

    initial begin
        logic       c;
        logic [7:0] s;
        logic [9:0] idx;
        int         ndone;
        int         dcyc;
        logic [11:0] ddig;
        logic       dneg;

        rst_n = 1'b0; start = 1'b0; S = '0; Cout = 1'b0; Sel = 1'b0;
        prev_neg = 1'b0; prev_dig = '0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_neg", {31'd0, neg}, 32'd0);
        check("rst_digits", {20'd0, bcd2, bcd1, bcd0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_pair(255, 255, 1'b0);   // 510
        do_pair(3, 5, 1'b1);       // -2
        do_pair(0, 127, 1'b1);     // -127
        do_pair(7, 7, 1'b1);       // 0
        do_pair(200, 55, 1'b1);
        do_pair(0, 255, 1'b1);     // -255

        // Second start mid-conversion must be dropped.
        @(negedge clk);
        Sel = 1'b0; Cout = 1'b0; S = 8'h10; start = 1'b1;
        ndone = 0; dcyc = 0; ddig = '0; dneg = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            start = (k == 4);
            if (k == 4) S = 8'h63;
            if (done) begin
                ndone++;
                dcyc = k;
                ddig = {bcd2, bcd1, bcd0};
                dneg = neg;
            end
        end
        start = 1'b0;
        check("ign_ndone", ndone, 1);
        check("ign_latency", dcyc, 10);
        check("ign_digits", {20'd0, ddig}, 32'h016);
        check("ign_neg", {31'd0, dneg}, 32'd0);
        prev_neg = 1'b0; prev_dig = 12'h016;

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        Sel = 1'b0; Cout = 1'b1; S = 8'hFE; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_neg", {31'd0, neg}, 32'd0);
        check("abort_digits", {20'd0, bcd2, bcd1, bcd0}, 32'd0);
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) ndone++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_nodone", ndone, 0);
        prev_neg = 1'b0; prev_dig = '0;
        do_pair(42, 0, 1'b0);

        // Every A,B for both operations; each distinct (Sel,Cout,S) is run once.
        for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
        for (int sl = 0; sl < 2; sl++) begin
            for (int a = 0; a < 256; a++) begin
                for (int b = 0; b < 256; b++) begin
                    sum_model(a, b, 1'(sl), c, s);
                    idx = {1'(sl), c, s};
                    if (!seen[idx]) begin
                        seen[idx]    = 1'b1;
                        ref_val[idx] = (sl != 0) ? a - b : a + b;
                        idx_q.push_back(int'(idx));
                    end
                end
            end
        end
        for (int i = idx_q.size() - 1; i > 0; i--) begin
            int j;
            int t;
            j = $urandom_range(i, 0);
            t = idx_q[i]; idx_q[i] = idx_q[j]; idx_q[j] = t;
        end
        foreach (idx_q[i]) begin
            idx = 10'(idx_q[i]);
            convert(idx[9], idx[8], idx[7:0], ref_val[idx] < 0, dec_digits(ref_val[idx]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/res_bcd_conv.md
RES_BCD_CONV -- requirements
Module: res_bcd_conv

Interface
REQ-001 Parameters: none; operand width fixed at 8 bits, result fixed at 3 BCD digits.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  convert request; sampled only in IDLE.
REQ-005 S  input  8  adder/subtractor sum output.
REQ-006 Cout  input  1  adder/subtractor carry-out.
REQ-007 Sel  input  1  operation of the sum: 0 add, 1 subtract.
REQ-008 busy  output  1  high while conversion in progress.
REQ-009 done  output  1  one-cycle pulse when results are updated.
REQ-010 neg  output  1  result sign: 1 = negative.
REQ-011 bcd2, bcd1, bcd0  output  4 each  hundreds, tens, units digit of the magnitude.

Function
REQ-012 The block SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-013 In IDLE with start=1 at edge t, the block SHALL capture the sign and a 9-bit magnitude, clear the BCD scratch, set the shift counter to 0, and enter SHIFT.
REQ-014 Magnitude/sign rules: Sel=0 -> neg=0, mag={Cout,S} (0..510); Sel=1,Cout=1 -> neg=0, mag={0,S}; Sel=1,Cout=0 -> neg=1, mag={0,~S}+1 (9-bit, so S=0x00 yields 256).
REQ-015 SHIFT SHALL run exactly 9 cycles of double-dabble: per cycle, each BCD digit >=5 gets +3, then {digits,mag} shifts left by one.
REQ-016 After the 9th SHIFT cycle the FSM SHALL enter DONE, registering bcd2/bcd1/bcd0 and neg on the same edge.
REQ-017 done SHALL be 1 only for the single DONE cycle, i.e. cycle t+10 relative to acceptance edge t; DONE SHALL then return to IDLE.
REQ-018 busy SHALL be 1 exactly during the 9 SHIFT cycles, 0 in IDLE and DONE.
REQ-019 start in SHIFT or DONE SHALL be ignored, not queued; minimum start-to-start spacing is 11 cycles.
REQ-020 Input changes on S/Cout/Sel after acceptance SHALL not affect the conversion in progress.
REQ-021 bcd2/bcd1/bcd0/neg SHALL hold their last value from DONE until the next DONE; they SHALL never show intermediate scratch values.
REQ-022 Each output digit SHALL be in 0..9; bcd2 SHALL be in 0..5.

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, neg=0, bcd2=bcd1=bcd0=0, counter and scratch to 0, regardless of clock.
REQ-024 Reset asserted mid-SHIFT SHALL abort the conversion without a done pulse; the first start after rst_n deasserts SHALL convert normally.

Structure
REQ-025 A shared package res_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and constants NSHIFT=9 and NDIG=3.
REQ-026 A combinational sub-module bcd_add3 (4-bit in, 4-bit out: +3 when >=5) SHALL be instantiated once per digit.
REQ-027 All registers SHALL reside in res_bcd_conv; no latches; one clock domain.

Verification
REQ-028 Sel=0, S=0xFE, Cout=1, start pulse -> done at t+10, neg=0, digits 5,1,0; busy high t+1..t+9.
REQ-029 Sel=1, S=0xFE, Cout=0 (3-5) -> neg=1, digits 0,0,2; Sel=1, S=0x81, Cout=0 (0-127) -> neg=1, digits 1,2,7.
REQ-030 Sel=1, S=0x00, Cout=1 (equal operands) -> neg=0, digits 0,0,0, done single-cycle.
REQ-031 start with S=0x10 (Sel=0,Cout=0), then at t+4 start with S=0x63 -> second start ignored, result 0,1,6, only one done pulse.
REQ-032 rst_n low at t+5 of a conversion -> outputs all 0 asynchronously, no done; start after release with Sel=0, S=0x2A, Cout=0 -> digits 0,4,2.
REQ-033 Bench SHALL sweep all A,B 0..255 through the sum model for both Sel values and compare against a reference signed-decimal model.
